// File: rtl/alu_mc.sv
// alu_mc: valid/ready ALU with single-cycle logic/arith ops and an optional
// multi-cycle unsigned shift-add multiplier.
//
// Parameters
//   WIDTH      operand/result width in bits (4..32)
//
// Ports
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   request present on op/a/b
//   in_ready   request accepted this cycle when high
//   op         4-bit opcode
//   a, b       operands (b is also the shift amount)
//   out_valid  r/flags/err hold an unconsumed result
//   out_ready  consumer takes the result
//   r          registered result
//   flags      registered {N, Z, V}
//   err        registered illegal-opcode indication
//
// Build option
//   ALU_MC_MUL_EN  when defined, op 4'b1010 is a WIDTH-cycle multiply; when
//                  undefined the multiplier hardware is absent and 4'b1010
//                  is handled as an illegal opcode.
//
// Results of single-cycle ops are registered on the accepting edge, so the
// result is visible in the cycle that follows the accept.

module alu_mc #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r,
  output logic [2:0]       flags,
  output logic             err
);

  // Opcode map; several operations have two encodings.
  localparam logic [3:0] OpAddA = 4'b1000;
  localparam logic [3:0] OpAddB = 4'b0001;
  localparam logic [3:0] OpSubA = 4'b1001;
  localparam logic [3:0] OpSubB = 4'b0010;
  localparam logic [3:0] OpMul  = 4'b1010;
  localparam logic [3:0] OpAndA = 4'b1011;
  localparam logic [3:0] OpAndB = 4'b0011;
  localparam logic [3:0] OpOrA  = 4'b1100;
  localparam logic [3:0] OpOrB  = 4'b0100;
  localparam logic [3:0] OpXor  = 4'b0101;
  localparam logic [3:0] OpShlA = 4'b1101;
  localparam logic [3:0] OpShlB = 4'b0110;
  localparam logic [3:0] OpShrA = 4'b1111;
  localparam logic [3:0] OpShrB = 4'b0111;

  logic             accept;
  logic             out_free;
  logic             is_mul;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             shift_big;
  logic [WIDTH-1:0] alu_res;
  logic             alu_v;
  logic             alu_err;

  // Result-register write port, shared by the ALU and the multiplier.
  logic             wr_en;
  logic [WIDTH-1:0] wr_res;
  logic             wr_v;
  logic             wr_err;

  // Output slot is free when empty or being drained on this edge.
  assign out_free = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

`ifdef ALU_MC_MUL_EN
  typedef enum logic [0:0] {StIdle, StMul} state_e;

  localparam int unsigned CntW = $clog2(WIDTH);

  state_e             state;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;     // multiplicand, shifted left each step
  logic [WIDTH-1:0]   mplier;    // multiplier, shifted right each step
  logic [CntW-1:0]    cnt;
  logic [2*WIDTH-1:0] acc_step;
  logic               mul_last;

  assign acc_step = acc + (mplier[0] ? mcand : '0);
  assign mul_last = (cnt == CntW'(WIDTH - 1));
  assign in_ready = (state == StIdle) && out_free;
`else
  // Only the idle state exists in this build.
  assign in_ready = out_free;
`endif

  // Single-cycle datapath.
  always_comb begin
    sum       = a + b;
    diff      = a + ~b + WIDTH'(1);
    shift_big = ({1'b0, b} >= (WIDTH + 1)'(WIDTH));
    alu_res   = '0;
    alu_v     = 1'b0;
    alu_err   = 1'b0;
    is_mul    = 1'b0;
    case (op)
      OpAddA, OpAddB: begin
        alu_res = sum;
        alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OpSubA, OpSubB: begin
        alu_res = diff;
        alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
`ifdef ALU_MC_MUL_EN
      OpMul: begin
        is_mul = 1'b1;
      end
`endif
      OpAndA, OpAndB: alu_res = a & b;
      OpOrA, OpOrB:   alu_res = a | b;
      OpXor:          alu_res = a ^ b;
      OpShlA, OpShlB: alu_res = shift_big ? '0 : (a << b);
      OpShrA, OpShrB: alu_res = shift_big ? '0 : (a >> b);
      default: begin
        // Illegal opcode: zero result, error flagged.
        alu_err = 1'b1;
      end
    endcase
  end

  // Select what, if anything, lands in the result registers this edge.
  always_comb begin
    wr_en  = accept && !is_mul;
    wr_res = alu_res;
    wr_v   = alu_v;
    wr_err = alu_err;
`ifdef ALU_MC_MUL_EN
    // Final partial product goes straight to the result registers.
    if ((state == StMul) && mul_last && out_free) begin
      wr_en  = 1'b1;
      wr_res = acc_step[WIDTH-1:0];
      wr_v   = |acc_step[2*WIDTH-1:WIDTH];
      wr_err = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      r         <= '0;
      flags     <= '0;
      err       <= 1'b0;
`ifdef ALU_MC_MUL_EN
      state     <= StIdle;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
`endif
    end else begin
      // A new result overrides the drain of the old one on the same edge.
      if (wr_en) begin
        out_valid <= 1'b1;
        r         <= wr_res;
        flags     <= {wr_res[WIDTH-1], (wr_res == '0), wr_v};
        err       <= wr_err;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

`ifdef ALU_MC_MUL_EN
      unique case (state)
        StIdle: begin
          if (accept && is_mul) begin
            state  <= StMul;
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            cnt    <= '0;
          end
        end
        StMul: begin
          // The last step waits if the result slot is still occupied.
          if (!mul_last || out_free) begin
            acc    <= acc_step;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (mul_last) begin
              state <= StIdle;
              cnt   <= '0;
            end
          end
        end
        default: state <= StIdle;
      endcase
`endif
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
module tb_alu_mc;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] r;
  logic [2:0]   flags;
  logic         err;

  int n_chk;
  int n_fail;

  alu_mc #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .r         (r),
    .flags     (flags),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
    logic [2:0] fl;
    logic       e;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference model: {r, N, Z, V, err} from plain integer arithmetic.
  function automatic logic [11:0] model(input logic [3:0] o, input int x, input int y);
    int sx, sy, ss, res;
    logic v, e;
    logic [7:0] r8;
    sx  = (x >= 128) ? x - 256 : x;
    sy  = (y >= 128) ? y - 256 : y;
    res = 0;
    v   = 1'b0;
    e   = 1'b0;
    case (o)
      4'b1000, 4'b0001: begin
        ss = sx + sy; res = (x + y) % 256; v = (ss > 127) || (ss < -128);
      end
      4'b1001, 4'b0010: begin
        ss = sx - sy; res = (x - y + 256) % 256; v = (ss > 127) || (ss < -128);
      end
      4'b1010: begin
`ifdef ALU_MC_MUL_EN
        res = (x * y) % 256; v = (x * y) > 255;
`else
        e = 1'b1;
`endif
      end
      4'b1011, 4'b0011: res = x & y;
      4'b1100, 4'b0100: res = x | y;
      4'b0101:          res = x ^ y;
      4'b1101, 4'b0110: res = (y >= 8) ? 0 : (x << y) % 256;
      4'b1111, 4'b0111: res = (y >= 8) ? 0 : x >> y;
      default:          e = 1'b1;
    endcase
    r8 = res[7:0];
    return {r8, r8[7], r8 == 8'h00, v, e};
  endfunction

  // Call at a negedge; returns at the negedge following the accepting edge.
  task automatic send(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
    int guard;
    guard = 0;
    in_valid = 1'b1;
    op = o;
    a = x;
    b = y;
    #1;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (!in_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: in_ready got 0 expected 1");
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  vec_t        vecs[18];
  logic [11:0] q[$];
  logic [11:0] exp_v;
  logic        took;
  logic        busy_ok;
  logic        seen;
  int          guard;

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    op = 4'h0;
    a = '0;
    b = '0;
    out_ready = 1'b1;

    vecs[0]  = '{4'b1000, 8'h7F, 8'h01, 8'h80, 3'b101, 1'b0};
    vecs[1]  = '{4'b1001, 8'h05, 8'h05, 8'h00, 3'b010, 1'b0};
    vecs[2]  = '{4'b1111, 8'h80, 8'h09, 8'h00, 3'b010, 1'b0};
    vecs[3]  = '{4'b1110, 8'h12, 8'h34, 8'h00, 3'b010, 1'b1};
    vecs[4]  = '{4'b0000, 8'hFF, 8'hFF, 8'h00, 3'b010, 1'b1};
    vecs[5]  = '{4'b0001, 8'hFF, 8'h01, 8'h00, 3'b010, 1'b0};
    vecs[6]  = '{4'b0010, 8'h80, 8'h01, 8'h7F, 3'b001, 1'b0};
    vecs[7]  = '{4'b1001, 8'h7F, 8'hFF, 8'h80, 3'b101, 1'b0};
    vecs[8]  = '{4'b1011, 8'hF0, 8'h3C, 8'h30, 3'b000, 1'b0};
    vecs[9]  = '{4'b0100, 8'hF0, 8'h0F, 8'hFF, 3'b100, 1'b0};
    vecs[10] = '{4'b0101, 8'hAA, 8'hAA, 8'h00, 3'b010, 1'b0};
    vecs[11] = '{4'b1101, 8'h01, 8'h07, 8'h80, 3'b100, 1'b0};
    vecs[12] = '{4'b0110, 8'hFF, 8'h08, 8'h00, 3'b010, 1'b0};
    vecs[13] = '{4'b0111, 8'h80, 8'h07, 8'h01, 3'b000, 1'b0};
    vecs[14] = '{4'b1111, 8'hF0, 8'h04, 8'h0F, 3'b000, 1'b0};
    vecs[15] = '{4'b1000, 8'h80, 8'h80, 8'h00, 3'b011, 1'b0};
    vecs[16] = '{4'b0011, 8'h0F, 8'h0F, 8'h0F, 3'b000, 1'b0};
    vecs[17] = '{4'b1100, 8'h00, 8'h00, 8'h00, 3'b010, 1'b0};

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'({r, flags, err}), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    // Directed table, consumer always ready.
    for (int i = 0; i < 18; i++) begin
      send(vecs[i].op, vecs[i].a, vecs[i].b);
      chk($sformatf("vec%0d_latency", i), 32'(out_valid), 32'd1);
      chk($sformatf("vec%0d_result", i), 32'({r, flags, err}),
          32'({vecs[i].r, vecs[i].fl, vecs[i].e}));
    end

    // Multiply 0x10 * 0x11.
    send(4'b1010, 8'h10, 8'h11);
`ifdef ALU_MC_MUL_EN
    busy_ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (in_ready || out_valid) busy_ok = 1'b0;
      @(negedge clk);
    end
    chk("mul_busy_8_cycles", 32'(busy_ok), 32'd1);
    chk("mul_out_valid", 32'(out_valid), 32'd1);
    chk("mul_result", 32'({r, flags, err}), 32'({8'h10, 3'b001, 1'b0}));
`else
    chk("mul_illegal_valid", 32'(out_valid), 32'd1);
    chk("mul_illegal_result", 32'({r, flags, err}), 32'({8'h00, 3'b010, 1'b1}));
`endif
    @(negedge clk);

    // Back-pressure: ADD result held, XOR waits, then both move on one edge.
    out_ready = 1'b0;
    send(4'b1000, 8'h01, 8'h02);
    chk("bp_add_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b1;
    op = 4'b0101;
    a = 8'hF0;
    b = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
      chk("bp_hold_r", 32'({out_valid, r}), 32'({1'b1, 8'h03}));
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_xor_result", 32'({out_valid, r, flags, err}), 32'({1'b1, 8'h0F, 3'b000, 1'b0}));
    @(negedge clk);
    chk("bp_drained", 32'(out_valid), 32'd0);

    // Reset three cycles into a multiply.
    send(4'b1010, 8'hFF, 8'hFF);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_result_cleared", 32'({r, flags, err}), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("abort_no_result", 32'(seen), 32'd0);

    // Random streaming traffic against the model, random back-pressure.
    for (int cyc = 0; cyc < 800; cyc++) begin
      if (!in_valid && ($urandom_range(0, 2) != 0)) begin
        in_valid = 1'b1;
        op = 4'($urandom_range(0, 15));
        a = 8'($urandom_range(0, 255));
        b = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 10)) : 8'($urandom_range(0, 255));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("rand_unexpected_result", 32'(out_valid), 32'd0);
        end else begin
          exp_v = q.pop_front();
          chk("rand_result", 32'({r, flags, err}), 32'(exp_v));
        end
      end
      took = in_valid && in_ready;
      if (took) q.push_back(model(op, int'(a), int'(b)));
      @(negedge clk);
      if (took) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    guard = 0;
    while (q.size() != 0 && guard < 40) begin
      #1;
      if (out_valid) begin
        exp_v = q.pop_front();
        chk("rand_drain_result", 32'({r, flags, err}), 32'(exp_v));
      end
      @(negedge clk);
      guard++;
    end
    chk("rand_queue_empty", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
